// File: rtl/scpad_req_arbiter.sv
// Round-robin, credit-limited arbiter sharing one registered SRAM request slot between
// the vector core (src 0) and the TCA (src 1). Define SCPAD_ARB_PERF_EN to add stall counters.
module scpad_req_arbiter #(
  parameter int unsigned REQ_W   = 64,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             vc_req_valid,
  input  logic [REQ_W-1:0] vc_req,
  output logic             vc_req_ready,
  input  logic             tca_req_valid,
  input  logic [REQ_W-1:0] tca_req,
  output logic             tca_req_ready,
  output logic             out_valid,
  output logic [REQ_W-1:0] out_req,
  output logic             out_src,
  input  logic             out_ready,
  input  logic             rsp_valid,
  input  logic             rsp_src,
  input  logic             flush,
  output logic             flush_done,
  output logic [CNT_W-1:0] vc_credits,
  output logic [CNT_W-1:0] tca_credits,
  output logic             cred_err
`ifdef SCPAD_ARB_PERF_EN
  ,
  output logic [31:0]      vc_stall_cnt,
  output logic [31:0]      tca_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(MAX_OUT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic             last_gnt;
  logic             slot_free;
  logic             vc_elig;
  logic             tca_elig;
  logic             gnt_vc;
  logic             gnt_tca;
  logic             vc_dec;
  logic             tca_dec;
  logic             slot_empty_nxt;
  logic [CNT_W-1:0] vc_credits_nxt;
  logic [CNT_W-1:0] tca_credits_nxt;

  // Grant plus completion in one cycle cancels; a completion at zero saturates.
  function automatic logic [CNT_W-1:0] cred_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    if (inc && !dec) return cnt + CNT_W'(1);
    if (dec && !inc && (cnt != '0)) return cnt - CNT_W'(1);
    return cnt;
  endfunction

  assign slot_free = !out_valid || out_ready;
  assign vc_elig   = vc_req_valid  && (vc_credits  < CRED_MAX) && (state == ST_RUN);
  assign tca_elig  = tca_req_valid && (tca_credits < CRED_MAX) && (state == ST_RUN);

  // On a tie the requester that did not win last time goes first.
  assign gnt_vc  = slot_free && vc_elig  && (!tca_elig || last_gnt);
  assign gnt_tca = slot_free && tca_elig && (!vc_elig  || !last_gnt);

  assign vc_req_ready  = gnt_vc  && !n_rst;
  assign tca_req_ready = gnt_tca && !n_rst;

  assign vc_dec  = rsp_valid && !rsp_src;
  assign tca_dec = rsp_valid && rsp_src;

  assign vc_credits_nxt  = cred_next(vc_credits,  gnt_vc,  vc_dec);
  assign tca_credits_nxt = cred_next(tca_credits, gnt_tca, tca_dec);
  assign slot_empty_nxt  = slot_free && !gnt_vc && !gnt_tca;

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state       <= ST_RUN;
      last_gnt    <= 1'b1;
      out_valid   <= 1'b0;
      out_req     <= '0;
      out_src     <= 1'b0;
      vc_credits  <= '0;
      tca_credits <= '0;
      cred_err    <= 1'b0;
      flush_done  <= 1'b0;
    end else begin
      if (gnt_vc || gnt_tca) begin
        out_valid <= 1'b1;
        out_req   <= gnt_tca ? tca_req : vc_req;
        out_src   <= gnt_tca;
        last_gnt  <= gnt_tca;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      vc_credits  <= vc_credits_nxt;
      tca_credits <= tca_credits_nxt;
      if ((vc_dec && (vc_credits == '0)) || (tca_dec && (tca_credits == '0))) begin
        cred_err <= 1'b1;
      end

      flush_done <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (flush) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Leave as soon as this cycle empties the slot and retires the last completion.
          if (slot_empty_nxt && (vc_credits_nxt == '0) && (tca_credits_nxt == '0)) begin
            state      <= ST_DONE;
            flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef SCPAD_ARB_PERF_EN
  // Saturating count of cycles each requester waits with a valid request.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      vc_stall_cnt  <= '0;
      tca_stall_cnt <= '0;
    end else begin
      if (vc_req_valid && !gnt_vc && (vc_stall_cnt != '1)) begin
        vc_stall_cnt <= vc_stall_cnt + 32'd1;
      end
      if (tca_req_valid && !gnt_tca && (tca_stall_cnt != '1)) begin
        tca_stall_cnt <= tca_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/scpad_req_arbiter.md
Name: scpad_req_arbiter

Overview:
- Request scheduler in front of the scratchpad SRAM port.
- Shares one SRAM request slot between the vector core (VC, src 0) and the tensor-core array (TCA, src 1).
- Grants are round-robin, and each requester is limited by an outstanding-transaction credit count.
- Provides a registered, backpressured output and a flush/drain sequence so the frontend pipe can be quiesced.

Parameters:
- REQ_W, 64: opaque request payload width (address, mask, write data, rw flag).
- MAX_OUT, 4: maximum in-flight requests per requester. Legal range 1..15.
- CNT_W, 4: width of each credit counter. Must satisfy 2^CNT_W > MAX_OUT.

Ports:
- clk, in, 1: clock.
- n_rst, in, 1: reset. Asynchronous, active-high (asserted = 1).
- vc_req_valid, in, 1: VC request present.
- vc_req, in, REQ_W: VC payload.
- vc_req_ready, out, 1: VC request accepted this cycle.
- tca_req_valid, in, 1: TCA request present.
- tca_req, in, REQ_W: TCA payload.
- tca_req_ready, out, 1: TCA request accepted this cycle.
- out_valid, out, 1: registered request to SRAM.
- out_req, out, REQ_W: registered payload.
- out_src, out, 1: source tag (0 = VC, 1 = TCA).
- out_ready, in, 1: SRAM accepts out_req.
- rsp_valid, in, 1: SRAM completion returned.
- rsp_src, in, 1: completion owner.
- flush, in, 1: request to drain.
- flush_done, out, 1: one-cycle pulse when drained.
- vc_credits, out, CNT_W: VC in-flight count.
- tca_credits, out, CNT_W: TCA in-flight count.
- cred_err, out, 1: sticky error, set on a completion with zero outstanding.

Behaviour:
- Reset: every output is 0. Slot is empty, counters are 0, FSM is in RUN, last_gnt = 1 (so VC wins the first tie), cred_err = 0. Reset asserted mid-operation discards the slot and all counters immediately.
- Eligibility for requester X:
  - X_req_valid = 1,
  - and registered X_credits < MAX_OUT,
  - and FSM = RUN.
  - A completion in the same cycle does not bypass the credit check.
- Slot free: slot is empty, or out_valid & out_ready this cycle (full throughput, 1 grant per cycle).
- Grant rule:
  - When the slot is free, grant exactly one eligible requester.
  - If both are eligible, grant the one not equal to last_gnt. last_gnt updates on every grant.
  - X_req_ready = grant to X (combinational from registered state and valids). Ready is never asserted to an ineligible requester.
- Latency: a request accepted in cycle N appears on out_valid/out_req/out_src in cycle N+1.
- Output hold: while out_valid = 1 and out_ready = 0, out_req and out_src hold stable and no grant is issued.
- Credits:
  - X_credits increments when X is granted.
  - X_credits decrements on rsp_valid with rsp_src = X.
  - Both in the same cycle leave the count unchanged.
  - A decrement at 0 leaves the count at 0 and sets cred_err. cred_err clears only on reset.
- FSM:
  - RUN: normal operation. When flush = 1, go to DRAIN. A grant in that same cycle still completes.
  - DRAIN: no grants. Go to DONE when the slot is empty and both counters are 0.
  - DONE: flush_done = 1 for exactly one cycle, then RUN.
  - flush is level-sampled only in RUN; flush held high re-enters DRAIN after DONE.

Optional Feature:
- Macro: SCPAD_ARB_PERF_EN.
- When defined:
  - Adds outputs vc_stall_cnt and tca_stall_cnt (32 bits each).
  - Each counts cycles where X_req_valid = 1 and X_req_ready = 0. Saturates at 0xFFFFFFFF.
  - Both reset to 0.
- When undefined:
  - Ports and counters are absent.
  - All other behaviour is identical.

Test Plan:
- VC and TCA both valid every cycle, out_ready = 1, prompt responses:
  - Grants alternate VC, TCA, VC, TCA.
  - out_src reads 0, 1, 0, 1 one cycle after each accept.
- TCA valid, no responses, MAX_OUT = 4:
  - Exactly 4 accepts; tca_credits = 4; tca_req_ready stays 0.
  - One rsp_valid with rsp_src = 1 drops tca_credits to 3, and ready returns the following cycle.
- out_ready held 0 for 5 cycles with a request in the slot:
  - out_req is stable; both readies are 0.
  - On release, the next grant is issued in the same cycle the slot is consumed.
- Same-cycle grant and completion for VC at vc_credits = 2: count stays 2.
- rsp_valid with rsp_src = 0 while vc_credits = 0: cred_err = 1 (sticky); count stays 0.
- flush with 3 VC requests in flight:
  - No grants are issued.
  - flush_done pulses 1 cycle after the third response and the slot empty.
  - Grants resume in the next cycle.
